// File: rtl/sseg_arb_pkg.sv
// Shared types for the seven-segment display share arbiter: FSM state
// encoding, requester indices and the registered display word.
package sseg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2,
        ST_BLANK = 2'd3
    } arb_state_e;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // Everything the display driver needs besides gnt/valid
    typedef struct packed {
        logic [13:0] cnt1;
        logic [6:0]  cnt2;
        logic [1:0]  mod_sel;
        logic        sign;
        logic        dp_en;
        logic [1:0]  dp_sel;
    } disp_t;

    // Ownership state that corresponds to a requester index
    function automatic arb_state_e own_state(input logic src);
        return (src == SRC_A) ? ST_OWN_A : ST_OWN_B;
    endfunction

endpackage

// File: rtl/sseg_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks.
module sseg_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    // Count 0..TICK_DIV-1 and wrap; tick marks the wrap cycle
    always_comb begin
        tick    = (presc_q == LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // Prescaler register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) presc_q <= '0;
        else        presc_q <= presc_d;
    end

endmodule

// File: rtl/sseg_share_arb.sv
// Time-shares one four-digit seven-segment display between requesters A
// and B, with a minimum dwell before pre-emption and a blank interval on
// every ownership change. All outputs are registered.
module sseg_share_arb
    import sseg_arb_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int DWELL    = 200,
    parameter int BLANK    = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_a,
    input  logic [13:0] a_cnt1,
    input  logic [6:0]  a_cnt2,
    input  logic [1:0]  a_mode,
    input  logic        a_sign,
    input  logic        a_dp_en,
    input  logic [1:0]  a_dp_sel,
    input  logic        req_b,
    input  logic [13:0] b_cnt1,
    input  logic [6:0]  b_cnt2,
    input  logic [1:0]  b_mode,
    input  logic        b_sign,
    input  logic        b_dp_en,
    input  logic [1:0]  b_dp_sel,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic [13:0] cnt1,
    output logic [6:0]  cnt2,
    output logic [1:0]  mod_sel,
    output logic        sign,
    output logic        dp_en,
    output logic [1:0]  dp_sel,
    output logic        valid
);

    localparam int DW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
    localparam int BW = (BLANK > 0) ? $clog2(BLANK + 1) : 1;
    localparam logic [DW-1:0] DWELL_V = DW'(DWELL);
    localparam logic [BW-1:0] BLANK_V = BW'(BLANK);

    logic tick;

    arb_state_e    state_q, state_d;
    logic          tgt_q, tgt_d;
    logic          last_q, last_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [BW-1:0] blank_q, blank_d;
    logic          gnt_a_q, gnt_a_d;
    logic          gnt_b_q, gnt_b_d;
    logic          valid_q, valid_d;
    disp_t         disp_q, disp_d;

    logic  tgt_req;
    logic  oth_req;
    disp_t disp_a;
    disp_t disp_b;

    sseg_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Next state, pending target and last-owner pointer
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        last_d  = last_q;
        tgt_req = (tgt_q == SRC_A) ? req_a : req_b;
        oth_req = (tgt_q == SRC_A) ? req_b : req_a;
        case (state_q)
            ST_IDLE: begin
                // Tie goes to whoever did not own the display last
                if (req_a && req_b)  state_d = (last_q == SRC_A) ? ST_OWN_B : ST_OWN_A;
                else if (req_a)      state_d = ST_OWN_A;
                else if (req_b)      state_d = ST_OWN_B;
            end
            ST_OWN_A: begin
                if (!req_a) begin
                    if (req_b) begin
                        state_d = ST_BLANK;
                        tgt_d   = SRC_B;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (req_b && dwell_q == DWELL_V) begin
                    state_d = ST_BLANK;
                    tgt_d   = SRC_B;
                end
            end
            ST_OWN_B: begin
                if (!req_b) begin
                    if (req_a) begin
                        state_d = ST_BLANK;
                        tgt_d   = SRC_A;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (req_a && dwell_q == DWELL_V) begin
                    state_d = ST_BLANK;
                    tgt_d   = SRC_A;
                end
            end
            ST_BLANK: begin
                // Requests are only looked at once the blank has expired
                if (blank_q == BLANK_V) begin
                    if (tgt_req)      state_d = own_state(tgt_q);
                    else if (oth_req) state_d = own_state(~tgt_q);
                    else              state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_OWN_A) last_d = SRC_A;
        if (state_d == ST_OWN_B) last_d = SRC_B;
    end

    // Dwell and blank counters: cleared outside their state, saturating on tick
    always_comb begin
        dwell_d = '0;
        blank_d = '0;
        if ((state_q == ST_OWN_A || state_q == ST_OWN_B) && state_d == state_q) begin
            dwell_d = dwell_q;
            if (tick && dwell_q != DWELL_V) dwell_d = dwell_q + 1'b1;
        end
        if (state_q == ST_BLANK && state_d == ST_BLANK) begin
            blank_d = blank_q;
            if (tick && blank_q != BLANK_V) blank_d = blank_q + 1'b1;
        end
    end

    // Output mux keyed on the next state so grants and data change together
    always_comb begin
        disp_a  = '{cnt1: a_cnt1, cnt2: a_cnt2, mod_sel: a_mode,
                    sign: a_sign, dp_en: a_dp_en, dp_sel: a_dp_sel};
        disp_b  = '{cnt1: b_cnt1, cnt2: b_cnt2, mod_sel: b_mode,
                    sign: b_sign, dp_en: b_dp_en, dp_sel: b_dp_sel};
        gnt_a_d = (state_d == ST_OWN_A);
        gnt_b_d = (state_d == ST_OWN_B);
        valid_d = gnt_a_d || gnt_b_d;
        disp_d  = '0;
        if (gnt_a_d)      disp_d = disp_a;
        else if (gnt_b_d) disp_d = disp_b;
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tgt_q   <= SRC_A;
            last_q  <= SRC_B;
            dwell_q <= '0;
            blank_q <= '0;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            valid_q <= 1'b0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            last_q  <= last_d;
            dwell_q <= dwell_d;
            blank_q <= blank_d;
            gnt_a_q <= gnt_a_d;
            gnt_b_q <= gnt_b_d;
            valid_q <= valid_d;
            disp_q  <= disp_d;
        end
    end

    assign gnt_a   = gnt_a_q;
    assign gnt_b   = gnt_b_q;
    assign valid   = valid_q;
    assign cnt1    = disp_q.cnt1;
    assign cnt2    = disp_q.cnt2;
    assign mod_sel = disp_q.mod_sel;
    assign sign    = disp_q.sign;
    assign dp_en   = disp_q.dp_en;
    assign dp_sel  = disp_q.dp_sel;

endmodule

// File: tb/tb_sseg_share_arb.sv
// Bench for sseg_share_arb with TICK_DIV=4, DWELL=3, BLANK=2.
module tb_sseg_share_arb;

    localparam logic [1:0] NO = 2'd0;
    localparam logic [1:0] OA = 2'd1;
    localparam logic [1:0] OB = 2'd2;

    localparam logic [6:0] A_CNT2 = 7'd5;
    localparam logic [1:0] A_MODE = 2'd2;
    localparam logic       A_SIGN = 1'b0;
    localparam logic       A_DPEN = 1'b1;
    localparam logic [1:0] A_DPS  = 2'd1;
    localparam logic [6:0] B_CNT2 = 7'd77;
    localparam logic [1:0] B_MODE = 2'd1;
    localparam logic       B_SIGN = 1'b1;
    localparam logic       B_DPEN = 1'b1;
    localparam logic [1:0] B_DPS  = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_a, req_b;
    logic [13:0] a_cnt1, b_cnt1;
    logic [6:0]  a_cnt2, b_cnt2;
    logic [1:0]  a_mode, b_mode, a_dp_sel, b_dp_sel;
    logic        a_sign, b_sign, a_dp_en, b_dp_en;
    logic        gnt_a, gnt_b, valid, sign, dp_en;
    logic [13:0] cnt1;
    logic [6:0]  cnt2;
    logic [1:0]  mod_sel, dp_sel;
    logic [29:0] obs;

    typedef struct {
        logic        ra;
        logic        rb;
        logic [13:0] ac;
        logic [13:0] bc;
        logic [1:0]  own;
        int          n;
    } vec_t;

    vec_t        tbl [22];
    logic [29:0] sb_q [$];
    logic [29:0] exp_w;
    int          checks = 0;
    int          passes = 0;

    sseg_share_arb #(.TICK_DIV(4), .DWELL(3), .BLANK(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .a_cnt1(a_cnt1), .a_cnt2(a_cnt2), .a_mode(a_mode),
        .a_sign(a_sign), .a_dp_en(a_dp_en), .a_dp_sel(a_dp_sel),
        .req_b(req_b), .b_cnt1(b_cnt1), .b_cnt2(b_cnt2), .b_mode(b_mode),
        .b_sign(b_sign), .b_dp_en(b_dp_en), .b_dp_sel(b_dp_sel),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .cnt1(cnt1), .cnt2(cnt2),
        .mod_sel(mod_sel), .sign(sign), .dp_en(dp_en), .dp_sel(dp_sel),
        .valid(valid)
    );

    always #5 clk = ~clk;

    assign obs = {gnt_a, gnt_b, valid, cnt1, cnt2, mod_sel, sign, dp_en, dp_sel};

    function automatic logic [29:0] exp_word(input logic [1:0] own,
                                             input logic [13:0] ac,
                                             input logic [13:0] bc);
        case (own)
            OA:      return {3'b101, ac, A_CNT2, A_MODE, A_SIGN, A_DPEN, A_DPS};
            OB:      return {3'b011, bc, B_CNT2, B_MODE, B_SIGN, B_DPEN, B_DPS};
            default: return '0;
        endcase
    endfunction

    task automatic check(input string name, input logic [29:0] want);
        checks++;
        if (obs === want) passes++;
        else $display("FAIL %s: got %h expected %h (gnt_a,gnt_b,valid,cnt1,cnt2,mod,sign,dp_en,dp_sel)",
                      name, obs, want);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        req_a  = 1'b0; req_b = 1'b0;
        a_cnt1 = 14'd1234; b_cnt1 = 14'd900;
        a_cnt2 = A_CNT2; a_mode = A_MODE; a_sign = A_SIGN; a_dp_en = A_DPEN; a_dp_sel = A_DPS;
        b_cnt2 = B_CNT2; b_mode = B_MODE; b_sign = B_SIGN; b_dp_en = B_DPEN; b_dp_sel = B_DPS;

        // {req_a, req_b, a_cnt1, b_cnt1, expected owner, cycles}; ticks land on every 4th edge after release
        tbl[0]  = '{1'b1, 1'b0, 14'd1234, 14'd900, OA, 1};  // grant at 1st edge after reset
        tbl[1]  = '{1'b1, 1'b0, 14'd42,   14'd900, OA, 1};  // data follows with 1 clk latency
        tbl[2]  = '{1'b0, 1'b0, 14'd42,   14'd900, NO, 1};  // release, nobody waiting -> IDLE
        tbl[3]  = '{1'b1, 1'b0, 14'd1234, 14'd900, OA, 5};  // A owns, one tick passes
        tbl[4]  = '{1'b1, 1'b1, 14'd1234, 14'd900, OA, 8};  // B contends, A keeps dwell
        tbl[5]  = '{1'b1, 1'b1, 14'd1234, 14'd900, NO, 8};  // pre-empted: blank for 2 ticks
        tbl[6]  = '{1'b0, 1'b1, 14'd1234, 14'd900, OB, 2};  // B owns
        tbl[7]  = '{1'b1, 1'b0, 14'd1234, 14'd901, NO, 6};  // B drops with A waiting -> blank
        tbl[8]  = '{1'b1, 1'b0, 14'd1234, 14'd900, OA, 1};  // A owns after blank
        tbl[9]  = '{1'b0, 1'b1, 14'd1234, 14'd900, NO, 7};  // A drops with B waiting -> blank
        tbl[10] = '{1'b0, 1'b1, 14'd1234, 14'd555, OB, 1};  // B owns after blank
        tbl[11] = '{1'b0, 1'b0, 14'd1234, 14'd555, NO, 1};  // IDLE
        tbl[12] = '{1'b1, 1'b1, 14'd7,    14'd8,   OA, 1};  // tie, last owner B -> A
        tbl[13] = '{1'b1, 1'b1, 14'd7,    14'd8,   OA, 1};  // dwell not reached
        tbl[14] = '{1'b0, 1'b0, 14'd7,    14'd8,   NO, 1};  // IDLE
        tbl[15] = '{1'b1, 1'b1, 14'd7,    14'd8,   OB, 1};  // tie, last owner A -> B
        tbl[16] = '{1'b0, 1'b0, 14'd7,    14'd8,   NO, 1};  // IDLE
        tbl[17] = '{1'b1, 1'b0, 14'd16383,14'd8,   OA, 1};  // full-scale cnt1
        tbl[18] = '{1'b0, 1'b1, 14'd16383,14'd8,   NO, 1};  // blank, target B
        tbl[19] = '{1'b1, 1'b0, 14'd16383,14'd8,   NO, 7};  // target drops during blank
        tbl[20] = '{1'b1, 1'b0, 14'd16383,14'd8,   OA, 1};  // expiry falls back to A
        tbl[21] = '{1'b0, 1'b0, 14'd16383,14'd8,   NO, 1};  // IDLE

        // Reset held with A requesting: nothing may appear, even across edges
        req_a = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_hold", '0);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                req_a  = tbl[i].ra;
                req_b  = tbl[i].rb;
                a_cnt1 = tbl[i].ac;
                b_cnt1 = tbl[i].bc;
                sb_q.push_back(exp_word(tbl[i].own, tbl[i].ac, tbl[i].bc));
                cyc();
                if (sb_q.size() == 0) begin
                    checks++;
                    $display("FAIL scoreboard_row%0d: got empty queue expected entry", i);
                end else begin
                    exp_w = sb_q.pop_front();
                    check($sformatf("row%0d_cyc%0d", i, k), exp_w);
                end
            end
        end

        // Async reset in the middle of a blank; A owned last before it
        req_a = 1'b1; req_b = 1'b0; a_cnt1 = 14'd321;
        cyc();
        check("rst_pre_own_a", exp_word(OA, 14'd321, b_cnt1));
        req_a = 1'b0; req_b = 1'b1;
        cyc();
        check("rst_pre_blank", '0);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_blank", '0);
        req_a = 1'b1; req_b = 1'b1;
        cyc();
        check("rst_held_blank", '0);
        rst_n = 1'b1;
        cyc();
        check("rst_tie_pointer_b", exp_word(OA, 14'd321, b_cnt1));

        // Async reset while B owns must clear outputs without a clock edge
        req_a = 1'b0; req_b = 1'b0;
        cyc();
        check("rst_idle", '0);
        req_b = 1'b1; b_cnt1 = 14'd9999;
        cyc();
        check("rst_pre_own_b", exp_word(OB, a_cnt1, 14'd9999));
        #2 rst_n = 1'b0;
        #1 check("rst_mid_own_b", '0);
        #10 rst_n = 1'b1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sseg_share_arb.md
Name: sseg_share_arb

Overview:
- Time-shares the single four-digit seven-segment display between two requesters, A and B.
- Each requester presents a complete display request: 14-bit count, 7-bit count, mode, sign and decimal-point control.
- The arbiter grants one requester at a time and enforces a minimum dwell time before switching ownership.
- It inserts a blanked interval (valid=0, dash pattern) on every ownership change.
- Its outputs drive the universal seven-segment driver's cnt1/cnt2/mod_sel/sign/dp_en/dp_sel/valid inputs directly.

Parameters:
TICK_DIV, 50000, clk cycles per arbitration tick (must be >= 1).
DWELL, 200, minimum ownership time in ticks before a contending requester can pre-empt (0 = pre-empt at once).
BLANK, 10, blank-interval length in ticks on an ownership change (0 = one clk cycle of blank).

Ports:
clk  in  1  system clock
rst_n  in  1  reset
req_a  in  1  requester A wants the display (level)
a_cnt1  in  14  A value for cnt1
a_cnt2  in  7  A value for cnt2
a_mode  in  2  A mod_sel
a_sign  in  1  A sign
a_dp_en  in  1  A decimal-point enable
a_dp_sel  in  2  A decimal-point digit
req_b, b_cnt1, b_cnt2, b_mode, b_sign, b_dp_en, b_dp_sel: same as the A set, for requester B
gnt_a  out  1  A owns the display
gnt_b  out  1  B owns the display
cnt1  out  14  to display
cnt2  out  7  to display
mod_sel  out  2  to display
sign  out  1  to display
dp_en  out  1  to display
dp_sel  out  2  to display
valid  out  1  to display; 0 shows the dash/blank pattern

Behaviour:
- Clocking and reset:
  - Single clock clk; rst_n is asynchronous, active-low.
  - All outputs are registered. Every output resets to 0: state IDLE, prescaler 0, dwell 0, blank 0.
  - The last-owner pointer resets to B, so A wins the first tie.
- Tick generation:
  - The prescaler counts 0..TICK_DIV-1 and wraps.
  - tick is a 1-cycle pulse on the wrap. It free-runs and is never cleared by state changes.
- State machine: IDLE, OWN_A, OWN_B, BLANK, plus a registered target (A/B).
- IDLE:
  - gnt=0, valid=0.
  - On a sampled edge with req_a and/or req_b high, go directly to OWN_x (no blank).
  - Tie rule: pick the requester that is NOT the last owner.
- OWN_x:
  - On entry: gnt_x=1, valid=1, dwell cleared, last-owner pointer set to x.
  - Each cycle, the display outputs load from x's inputs. Latency is exactly 1 clk from requester input to output.
  - The dwell counter increments on tick and saturates at DWELL.
  - Transitions are evaluated each cycle, in this priority order:
    1. req_x low and other req high -> BLANK, target = other.
    2. req_x low and other req low -> IDLE.
    3. req_x high, other req high, dwell == DWELL -> BLANK, target = other.
    4. Otherwise stay.
  - gnt_x and valid drop in the same cycle the state leaves OWN_x.
- BLANK:
  - gnt both 0, valid=0. The blank counter clears on entry and increments on tick.
  - Expiry occurs when the count equals BLANK. With BLANK=0, expiry is the first cycle in BLANK.
  - At expiry: target req high -> OWN_target; else other req high -> OWN_other; else -> IDLE.
  - Before expiry, requests are ignored.
- Outputs when not in OWN:
  - cnt1, cnt2, mod_sel, sign, dp_en and dp_sel are all 0.
  - gnt_a and gnt_b are never both 1.
- Counter widths:
  - All counters are sized by $clog2(param+1) and never wrap; dwell and blank saturate.
- Requests are assumed synchronous to clk; no synchroniser is included.
- Asserting rst_n low in any state forces all outputs to 0 immediately, with no clock edge.

Decomposition:
- Package sseg_arb_pkg holds the state encoding (IDLE=0, OWN_A=1, OWN_B=2, BLANK=3) and the source index constants (SRC_A=0, SRC_B=1).
- One sub-module, sseg_tick_gen (parameter TICK_DIV; ports clk, rst_n, tick), holds the prescaler.
- The arbiter FSM, dwell/blank counters and output mux stay in sseg_share_arb.

Test Plan:
Bench parameters: TICK_DIV=4, DWELL=3, BLANK=2.
1. Reset: hold rst_n=0 with req_a=1 -> every output 0. Release -> gnt_a=1, valid=1 at the 1st edge after release.
2. Solo grant: from IDLE, raise req_a with a_cnt1=1234, a_mode=2 -> next edge gnt_a=1, cnt1=1234, mod_sel=2, valid=1. Change a_cnt1 to 42 -> cnt1=42 one cycle later.
3. Contention: A owns, B raises req_b 1 tick after grant -> A keeps the display until 3 ticks after its grant. Then valid=0 with both gnts 0 for 2 ticks, then gnt_b=1 with B's values.
4. Release: A owns, req_a drops, req_b low -> next edge IDLE, gnt_a=0, valid=0, cnt1=0. Same with req_b high -> BLANK, then OWN_B after 2 ticks.
5. Fairness: both requests rise together from IDLE after reset -> A granted. A drops, the blank completes, B owns; B drops, then both raise together from IDLE -> A granted (last owner B).
6. Async reset mid-BLANK: assert rst_n=0 between clk edges -> outputs 0 within that cycle, and the pointer returns to B.
